// File: rtl/pc_gen.sv
// Fetch-stage PC generator: prioritised redirects, stall hold, pending redirect latch, advance counter.
// Define PC_ALIGN_CHECK_EN to force targets to INC alignment and pulse misalign on correction.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              NUM_STALL = 3,
  parameter int              INC       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_STALL-1:0] stall,
  input  logic                 trap_valid,
  input  logic [XLEN-1:0]      trap_pc,
  input  logic                 flush_valid,
  input  logic [XLEN-1:0]      flush_pc,
  input  logic                 jump_valid,
  input  logic [XLEN-1:0]      jump_pc,
  output logic [XLEN-1:0]      pc_out,
  output logic                 pc_valid,
  output logic                 redirect_pend,
  output logic [31:0]          fetch_cnt,
  output logic                 misalign
);

  localparam logic [XLEN-1:0] INC_V     = XLEN'(INC);
  localparam logic [1:0]      PRI_TRAP  = 2'd0;
  localparam logic [1:0]      PRI_FLUSH = 2'd1;
  localparam logic [1:0]      PRI_JUMP  = 2'd2;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_v_q, pend_v_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [1:0]      pend_pri_q, pend_pri_d;
  logic [31:0]     cnt_q, cnt_d;

  logic            req_v;
  logic [XLEN-1:0] req_pc;
  logic [1:0]      req_pri;
  logic            stalled;
  logic            take_req;
  logic            load;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] tgt_al;
  logic            mis_d;

  always_comb begin
    req_v   = 1'b1;
    req_pc  = trap_pc;
    req_pri = PRI_TRAP;
    if (trap_valid) begin
      req_pc  = trap_pc;
      req_pri = PRI_TRAP;
    end else if (flush_valid) begin
      req_pc  = flush_pc;
      req_pri = PRI_FLUSH;
    end else if (jump_valid) begin
      req_pc  = jump_pc;
      req_pri = PRI_JUMP;
    end else begin
      req_v   = 1'b0;
      req_pc  = jump_pc;
      req_pri = PRI_JUMP;
    end
  end

  assign stalled = |stall;
  // Lower encoding is higher priority; a tie goes to the newer request.
  assign take_req = req_v & (~pend_v_q | (req_pri <= pend_pri_q));

  always_comb begin
    pend_v_d   = pend_v_q;
    pend_pc_d  = pend_pc_q;
    pend_pri_d = pend_pri_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    tgt        = req_pc;
    if (stalled) begin
      if (take_req) begin
        pend_v_d   = 1'b1;
        pend_pc_d  = req_pc;
        pend_pri_d = req_pri;
      end
    end else begin
      cnt_d    = cnt_q + 32'd1;
      pend_v_d = 1'b0;
      if (take_req) begin
        load = 1'b1;
        tgt  = req_pc;
      end else if (pend_v_q) begin
        load = 1'b1;
        tgt  = pend_pc_q;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [XLEN-1:0] AMASK = XLEN'(INC - 1);
  logic mis_q;

  assign tgt_al   = tgt & ~AMASK;
  assign mis_d    = load & (|(tgt & AMASK));
  assign misalign = mis_q;

  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end
`else
  assign tgt_al   = tgt;
  assign mis_d    = 1'b0;
  assign misalign = mis_d;
`endif

  always_comb begin
    pc_d = pc_q;
    if (!stalled) pc_d = load ? tgt_al : pc_q + INC_V;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      pend_v_q   <= 1'b0;
      pend_pc_q  <= '0;
      pend_pri_q <= PRI_JUMP;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_pc_q  <= pend_pc_d;
      pend_pri_q <= pend_pri_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_out        = pc_q;
  assign pc_valid      = ~stalled & ~pend_v_q;
  assign redirect_pend = pend_v_q;
  assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected state queued per driven cycle, checked after each edge.
// Align expectations follow PC_ALIGN_CHECK_EN as compiled.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  stall;
  logic        trap_valid, flush_valid, jump_valid;
  logic [31:0] trap_pc, flush_pc, jump_pc;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        redirect_pend;
  logic [31:0] fetch_cnt;
  logic        misalign;

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN(32), .RESET_VEC(RV), .NUM_STALL(3), .INC(4)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .flush_valid(flush_valid), .flush_pc(flush_pc),
    .jump_valid(jump_valid), .jump_pc(jump_pc),
    .pc_out(pc_out), .pc_valid(pc_valid),
    .redirect_pend(redirect_pend),
    .fetch_cnt(fetch_cnt), .misalign(misalign)
  );

  typedef struct {
    logic        r;
    logic [2:0]  st;
    logic [2:0]  k;
    logic [31:0] t;
    logic [31:0] t2;
    logic [31:0] epc;
    logic        ep;
    logic        em;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic [31:0] cnt;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic        cur_pend = 1'b0;
  logic [31:0] cnt_m = '0;
  logic        exp_valid;

  // k = {trap, flush, jump}; the highest set source gets t, the rest get t2
  function automatic stim_t mk(input logic r, input logic [2:0] st,
                               input logic [2:0] k, input logic [31:0] t,
                               input logic [31:0] t2, input logic [31:0] epc,
                               input logic ep, input logic em);
    stim_t s;
    s.r = r; s.st = st; s.k = k; s.t = t; s.t2 = t2;
    s.epc = epc; s.ep = ep; s.em = em;
    return s;
  endfunction

  task automatic apply(input stim_t v);
    rst         = v.r;
    stall       = v.st;
    trap_valid  = v.k[2];
    flush_valid = v.k[1];
    jump_valid  = v.k[0];
    trap_pc     = v.t;
    flush_pc    = v.k[2] ? v.t2 : v.t;
    jump_pc     = (v.k[2] | v.k[1]) ? v.t2 : v.t;
    exp_valid   = (v.st == 3'b000) && !cur_pend;
    if (v.r) cnt_m = '0;
    else if (v.st == 3'b000) cnt_m = cnt_m + 32'd1;
    sb.push_back('{pc: v.epc, pend: v.ep, cnt: cnt_m, mis: v.em});
    cur_pend = v.ep;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t v[$];
    exp_t  e;
    v.push_back(mk(1, 3'b000, 3'b000, 0, 0, RV, 0, 0));
    v.push_back(mk(1, 3'b000, 3'b101, 32'h80, 32'h400, RV, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      tick();
      e = sb.pop_front();
      tests++;
      if ({pc_out, redirect_pend, fetch_cnt, misalign} !== {e.pc, e.pend, e.cnt, e.mis}) begin
        $display("FAIL reset[%0d] got pc=%h pend=%b cnt=%0d mis=%b want pc=%h pend=%b cnt=%0d mis=%b",
                 i, pc_out, redirect_pend, fetch_cnt, misalign, e.pc, e.pend, e.cnt, e.mis);
        fails++;
      end
    end
    rst   = 1'b0;
    stall = 3'b011;
    #1;
    tests++;
    if (pc_valid !== 1'b0) begin
      $display("FAIL reset.valid_stalled got %b want 0", pc_valid);
      fails++;
    end
    stall = 3'b000;
    #1;
    tests++;
    if (pc_valid !== 1'b1) begin
      $display("FAIL reset.valid_free got %b want 1", pc_valid);
      fails++;
    end
  endtask

  task automatic run_table(input string name, input stim_t v[$]);
    exp_t e;
    foreach (v[i]) begin
      apply(v[i]);
      if (!v[i].r) begin
        tests++;
        if (pc_valid !== exp_valid) begin
          $display("FAIL %s.valid[%0d] got %b want %b", name, i, pc_valid, exp_valid);
          fails++;
        end
      end
      tick();
      e = sb.pop_front();
      tests++;
      if ({pc_out, redirect_pend, fetch_cnt, misalign} !== {e.pc, e.pend, e.cnt, e.mis}) begin
        $display("FAIL %s[%0d] got pc=%h pend=%b cnt=%0d mis=%b want pc=%h pend=%b cnt=%0d mis=%b",
                 name, i, pc_out, redirect_pend, fetch_cnt, misalign, e.pc, e.pend, e.cnt, e.mis);
        fails++;
      end
    end
  endtask

  task automatic test_free_run();
    stim_t v[$];
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h104, 0, 0));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h108, 0, 0));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h10C, 0, 0));
    run_table("free_run", v);
    tests++;
    if (fetch_cnt !== 32'd3) begin
      $display("FAIL free_run.cnt got %0d want 3", fetch_cnt);
      fails++;
    end
  endtask

  task automatic test_lost_redirect();
    stim_t v[$];
    v.push_back(mk(0, 3'b010, 3'b000, 0, 0, 32'h10C, 0, 0));
    v.push_back(mk(0, 3'b010, 3'b001, 32'h400, 0, 32'h10C, 1, 0));
    v.push_back(mk(0, 3'b010, 3'b000, 0, 0, 32'h10C, 1, 0));
    v.push_back(mk(0, 3'b010, 3'b000, 0, 0, 32'h10C, 1, 0));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h400, 0, 0));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h404, 0, 0));
    run_table("lost_redirect", v);
  endtask

  task automatic test_priority();
    stim_t v[$];
    v.push_back(mk(0, 3'b001, 3'b001, 32'h400, 0, 32'h404, 1, 0));
    v.push_back(mk(0, 3'b100, 3'b100, 32'h80, 0, 32'h404, 1, 0));
    v.push_back(mk(0, 3'b011, 3'b010, 32'h200, 0, 32'h404, 1, 0));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h80, 0, 0));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h84, 0, 0));
    v.push_back(mk(0, 3'b010, 3'b010, 32'h200, 0, 32'h84, 1, 0));
    v.push_back(mk(0, 3'b101, 3'b010, 32'h300, 0, 32'h84, 1, 0));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h300, 0, 0));
    run_table("priority", v);
  endtask

  task automatic test_simultaneous();
    stim_t v[$];
    v.push_back(mk(0, 3'b001, 3'b001, 32'h400, 0, 32'h300, 1, 0));
    v.push_back(mk(0, 3'b000, 3'b100, 32'h80, 0, 32'h80, 0, 0));
    v.push_back(mk(0, 3'b000, 3'b101, 32'h1000, 32'h2000, 32'h1000, 0, 0));
    v.push_back(mk(0, 3'b100, 3'b100, 32'h500, 0, 32'h1000, 1, 0));
    v.push_back(mk(0, 3'b000, 3'b001, 32'h600, 0, 32'h500, 0, 0));
    v.push_back(mk(0, 3'b000, 3'b011, 32'h700, 32'h800, 32'h700, 0, 0));
    run_table("simultaneous", v);
  endtask

  task automatic test_wrap_reset();
    stim_t v[$];
    v.push_back(mk(0, 3'b000, 3'b100, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 0));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h0, 0, 0));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h4, 0, 0));
    v.push_back(mk(0, 3'b010, 3'b001, 32'h400, 0, 32'h4, 1, 0));
    v.push_back(mk(1, 3'b010, 3'b100, 32'h80, 0, RV, 0, 0));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, RV + 32'h4, 0, 0));
    run_table("wrap_reset", v);
  endtask

  task automatic test_align();
    stim_t v[$];
`ifdef PC_ALIGN_CHECK_EN
    v.push_back(mk(0, 3'b000, 3'b001, 32'h403, 0, 32'h400, 0, 1));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h404, 0, 0));
    v.push_back(mk(0, 3'b001, 3'b001, 32'h201, 0, 32'h404, 1, 0));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h200, 0, 1));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h204, 0, 0));
`else
    v.push_back(mk(0, 3'b000, 3'b001, 32'h403, 0, 32'h403, 0, 0));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h407, 0, 0));
    v.push_back(mk(0, 3'b001, 3'b001, 32'h201, 0, 32'h407, 1, 0));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h201, 0, 0));
    v.push_back(mk(0, 3'b000, 3'b000, 0, 0, 32'h205, 0, 0));
`endif
    run_table("align", v);
  endtask

  initial begin
    rst         = 1'b1;
    stall       = '0;
    trap_valid  = 1'b0;
    flush_valid = 1'b0;
    jump_valid  = 1'b0;
    trap_pc     = '0;
    flush_pc    = '0;
    jump_pc     = '0;
    test_reset();
    test_free_run();
    test_lost_redirect();
    test_priority();
    test_simultaneous();
    test_wrap_reset();
    test_align();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
